// File: rtl/x4_approx_mul_core_if.sv
// ----------------------------------------------------------------------------
// x4_approx_mul_core_if
//
// Operand/result bundle for the 4x4 approximate multiplier core.
//
// Signals:
//   in_valid    : a/b carry an operand pair this cycle
//   a, b        : 4-bit unsigned operands
//   out         : 8-bit registered (approximate) product
//   out_valid   : out holds a product produced from the previous cycle's input
//   approx_hit  : only with X4_APPROX_MUL_ERR_FLAG_EN; out differs from the
//                 exact product
//
// Modports:
//   master : producer of operands / consumer of results
//   slave  : the multiplier core
// ----------------------------------------------------------------------------
interface x4_approx_mul_core_if;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] out;
  logic       out_valid;
`ifdef X4_APPROX_MUL_ERR_FLAG_EN
  logic       approx_hit;
`endif

  modport master (
    output in_valid,
    output a,
    output b,
`ifdef X4_APPROX_MUL_ERR_FLAG_EN
    input  approx_hit,
`endif
    input  out,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
`ifdef X4_APPROX_MUL_ERR_FLAG_EN
    output approx_hit,
`endif
    output out,
    output out_valid
  );
endinterface

// File: rtl/x4_approx_mul_core.sv
// ----------------------------------------------------------------------------
// x4_approx_mul_core
//
// Registered 4x4 unsigned approximate multiplier built from four 2x2
// sub-multipliers. The first N4 sub-products (index order P0..P3) use the
// approximate 2x2 cell (3*3 = 7), the rest use the exact cell (3*3 = 9).
// Partial products are summed exactly at 8 bits, then registered once.
//
// Sub-products:
//   P0 = aL*bL (<<0), P1 = aH*bL (<<2), P2 = aL*bH (<<2), P3 = aH*bH (<<4)
//
// Parameters:
//   N4 : number of approximate sub-multipliers, 0..4 (larger values act as 4)
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset (clears out, out_valid, approx_hit)
//   bus : x4_approx_mul_core_if.slave (in_valid, a, b -> out, out_valid,
//         approx_hit)
//
// Optional feature macro: X4_APPROX_MUL_ERR_FLAG_EN
//   Defined   : bus.approx_hit is produced, registered with out.
//   Undefined : no error-flag logic.
// ----------------------------------------------------------------------------
module x4_approx_mul_core #(
  parameter int N4 = 0
) (
  input logic                  clk,
  input logic                  rst,
  x4_approx_mul_core_if.slave  bus
);

  // Effective count of approximate cells; out-of-range values saturate.
  localparam int N4_EFF = (N4 > 4) ? 4 : ((N4 < 0) ? 0 : N4);

  // Exact 2x2 cell: 4-bit product, 3*3 = 9 (1001).
  function automatic logic [3:0] mul2_exact(input logic [1:0] x,
                                            input logic [1:0] y);
    logic [3:0] p;
    p[0] = x[0] & y[0];
    p[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
    p[2] = x[1] & y[1] & ~(x[0] & y[0]);
    p[3] = x[1] & y[1] & x[0] & y[0];
    return p;
  endfunction

  // Approximate 2x2 cell: 3-bit product, identical except 3*3 = 7 (111).
  // Replacing the XOR with OR and dropping the carry term removes p[3].
  function automatic logic [2:0] mul2_approx(input logic [1:0] x,
                                             input logic [1:0] y);
    logic [2:0] p;
    p[0] = x[0] & y[0];
    p[1] = (x[1] & y[0]) | (x[0] & y[1]);
    p[2] = x[1] & y[1];
    return p;
  endfunction

  // Operand routing for the four sub-products, indexed as P0..P3.
  logic [1:0] op_x [4];
  logic [1:0] op_y [4];

  assign op_x[0] = bus.a[1:0];
  assign op_y[0] = bus.b[1:0];
  assign op_x[1] = bus.a[3:2];
  assign op_y[1] = bus.b[1:0];
  assign op_x[2] = bus.a[1:0];
  assign op_y[2] = bus.b[3:2];
  assign op_x[3] = bus.a[3:2];
  assign op_y[3] = bus.b[3:2];

  logic [3:0] pp [4];
`ifdef X4_APPROX_MUL_ERR_FLAG_EN
  logic [3:0] hit;
`endif

  for (genvar gi = 0; gi < 4; gi++) begin : g_sub
    if (gi < N4_EFF) begin : g_approx
      assign pp[gi] = {1'b0, mul2_approx(op_x[gi], op_y[gi])};
`ifdef X4_APPROX_MUL_ERR_FLAG_EN
      // The approximate cell is wrong only for the 3*3 operand pair.
      assign hit[gi] = (&op_x[gi]) & (&op_y[gi]);
`endif
    end else begin : g_exact
      assign pp[gi] = mul2_exact(op_x[gi], op_y[gi]);
`ifdef X4_APPROX_MUL_ERR_FLAG_EN
      assign hit[gi] = 1'b0;
`endif
    end
  end

  // Exact 8-bit summation; the largest possible sum (225) cannot overflow.
  logic [7:0] sum;
  assign sum = {4'b0000, pp[0]}
             + {2'b00, pp[1], 2'b00}
             + {2'b00, pp[2], 2'b00}
             + {pp[3], 4'b0000};

  logic [7:0] out_q;
  logic       out_valid_q;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for every registered signal, so all
    // flops update together from values sampled before the edge.
    if (rst) begin
      out_q       <= 8'd0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        out_q <= sum;
      end
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;

`ifdef X4_APPROX_MUL_ERR_FLAG_EN
  logic approx_hit_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      approx_hit_q <= 1'b0;
    end else if (bus.in_valid) begin
      approx_hit_q <= |hit;
    end
  end

  assign bus.approx_hit = approx_hit_q;
`endif

endmodule

// File: tb/tb_x4_approx_mul_core.sv
// ----------------------------------------------------------------------------
// tb_x4_approx_mul_core
//
// Six core instances (N4 = 0,1,2,3,4 and 7, the last saturating to 4) share
// one operand stream. Expected results are queued per instance when an
// operand pair is issued; a monitor pops and compares whenever an instance
// raises out_valid. Reset and hold behaviour are checked directly.
// ----------------------------------------------------------------------------
module tb_x4_approx_mul_core;

  localparam int NDUT = 6;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;

  int n4_of [NDUT] = '{0, 1, 2, 3, 4, 7};

  int n_vec = 0;
  int n_bad = 0;

  // Expected {approx_hit, out} per instance.
  logic [8:0] exp_q [NDUT][$];

  x4_approx_mul_core_if bus0 ();
  x4_approx_mul_core_if bus1 ();
  x4_approx_mul_core_if bus2 ();
  x4_approx_mul_core_if bus3 ();
  x4_approx_mul_core_if bus4 ();
  x4_approx_mul_core_if bus5 ();

  assign bus0.in_valid = in_valid; assign bus0.a = a; assign bus0.b = b;
  assign bus1.in_valid = in_valid; assign bus1.a = a; assign bus1.b = b;
  assign bus2.in_valid = in_valid; assign bus2.a = a; assign bus2.b = b;
  assign bus3.in_valid = in_valid; assign bus3.a = a; assign bus3.b = b;
  assign bus4.in_valid = in_valid; assign bus4.a = a; assign bus4.b = b;
  assign bus5.in_valid = in_valid; assign bus5.a = a; assign bus5.b = b;

  x4_approx_mul_core #(.N4(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  x4_approx_mul_core #(.N4(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  x4_approx_mul_core #(.N4(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  x4_approx_mul_core #(.N4(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
  x4_approx_mul_core #(.N4(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  x4_approx_mul_core #(.N4(7)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

  logic [7:0]      out_w [NDUT];
  logic [NDUT-1:0] ov_w;
  logic [NDUT-1:0] hit_w;

  assign out_w[0] = bus0.out; assign ov_w[0] = bus0.out_valid;
  assign out_w[1] = bus1.out; assign ov_w[1] = bus1.out_valid;
  assign out_w[2] = bus2.out; assign ov_w[2] = bus2.out_valid;
  assign out_w[3] = bus3.out; assign ov_w[3] = bus3.out_valid;
  assign out_w[4] = bus4.out; assign ov_w[4] = bus4.out_valid;
  assign out_w[5] = bus5.out; assign ov_w[5] = bus5.out_valid;

`ifdef X4_APPROX_MUL_ERR_FLAG_EN
  assign hit_w = {bus5.approx_hit, bus4.approx_hit, bus3.approx_hit,
                  bus2.approx_hit, bus1.approx_hit, bus0.approx_hit};
`else
  assign hit_w = '0;
`endif

  // Directed vectors with hand-computed results per instance (N4 = 0,1,2,3,4,7).
  // 15*15: 225 minus 2 (P0), 8 (P1), 8 (P2), 32 (P3) for each approximate hit.
  localparam int NDIR = 4;
  logic [3:0] dir_a   [NDIR]       = '{4'd15, 4'd2, 4'd3, 4'd12};
  logic [3:0] dir_b   [NDIR]       = '{4'd15, 4'd2, 4'd3, 4'd12};
  logic [7:0] dir_out [NDIR][NDUT] = '{'{8'd225, 8'd223, 8'd215, 8'd207, 8'd175, 8'd175},
                                       '{8'd4,   8'd4,   8'd4,   8'd4,   8'd4,   8'd4  },
                                       '{8'd9,   8'd7,   8'd7,   8'd7,   8'd7,   8'd7  },
                                       '{8'd144, 8'd144, 8'd144, 8'd144, 8'd112, 8'd112}};
  logic       dir_hit [NDIR][NDUT] = '{'{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1},
                                       '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
                                       '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1},
                                       '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Error-rule model: exact product minus 2*weight for every approximate
  // sub-product whose two 2-bit operands are both 3.
  function automatic logic [8:0] model(input int n4, input logic [3:0] x,
                                       input logic [3:0] y);
    int         eff;
    int         r;
    int         w;
    logic       h;
    logic [1:0] ox;
    logic [1:0] oy;
    eff = (n4 > 4) ? 4 : n4;
    r   = int'(x) * int'(y);
    h   = 1'b0;
    for (int i = 0; i < eff; i++) begin
      ox = (i == 1 || i == 3) ? x[3:2] : x[1:0];
      oy = (i >= 2) ? y[3:2] : y[1:0];
      w  = (i == 0) ? 1 : ((i == 3) ? 16 : 4);
      if (ox == 2'd3 && oy == 2'd3) begin
        r = r - 2 * w;
        h = 1'b1;
      end
    end
    return {h, r[7:0]};
  endfunction

  // Monitor: compare every presented output against the queued expectation.
  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (ov_w[k]) begin
        if (exp_q[k].size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL dut%0d unexpected output: got out=%0d, expected no output",
                   k, out_w[k]);
        end else begin
          logic [8:0] e;
          e = exp_q[k].pop_front();
          check($sformatf("dut%0d out", k), int'(out_w[k]), int'(e[7:0]));
`ifdef X4_APPROX_MUL_ERR_FLAG_EN
          check($sformatf("dut%0d approx_hit", k), int'(hit_w[k]), int'(e[8]));
`endif
        end
      end
    end
  end

  task automatic drive(input logic [3:0] va, input logic [3:0] vb,
                       input logic v, input logic r);
    @(negedge clk);
    a        = va;
    b        = vb;
    in_valid = v;
    rst      = r;
  endtask

  // Reset/idle state check, taken just after a rising edge.
  task automatic check_idle(input string tag);
    @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("%s dut%0d out", tag, k), int'(out_w[k]), 0);
      check($sformatf("%s dut%0d out_valid", tag, k), int'(ov_w[k]), 0);
`ifdef X4_APPROX_MUL_ERR_FLAG_EN
      check($sformatf("%s dut%0d approx_hit", tag, k), int'(hit_w[k]), 0);
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = 4'd0;
    b        = 4'd0;

    // Reset state.
    drive(4'd0, 4'd0, 1'b0, 1'b1);
    check_idle("reset");
    for (int k = 0; k < NDUT; k++) exp_q[k].delete();

    // Directed vectors, back to back.
    for (int i = 0; i < NDIR; i++) begin
      drive(dir_a[i], dir_b[i], 1'b1, 1'b0);
      for (int k = 0; k < NDUT; k++) exp_q[k].push_back({dir_hit[i][k], dir_out[i][k]});
    end

    // Full operand sweep, one pair per cycle.
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        drive(4'(x), 4'(y), 1'b1, 1'b0);
        for (int k = 0; k < NDUT; k++) exp_q[k].push_back(model(n4_of[k], 4'(x), 4'(y)));
      end
    end
    drive(4'd0, 4'd0, 1'b0, 1'b0);
    drive(4'd0, 4'd0, 1'b0, 1'b0);

    // Hold: out keeps 30 while in_valid is low and operands wander.
    drive(4'd5, 4'd6, 1'b1, 1'b0);
    for (int k = 0; k < NDUT; k++) exp_q[k].push_back({1'b0, 8'd30});
    for (int i = 0; i < 3; i++) begin
      drive(4'(15 - i), 4'(9 + i), 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check($sformatf("hold%0d dut0 out", i), int'(out_w[0]), 30);
      check($sformatf("hold%0d dut4 out", i), int'(out_w[4]), 30);
      check($sformatf("hold%0d dut0 out_valid", i), int'(ov_w[0]), 0);
      check($sformatf("hold%0d dut4 out_valid", i), int'(ov_w[4]), 0);
    end

    // Reset has priority over in_valid: the 15*15 inputs are dropped.
    drive(4'd15, 4'd15, 1'b1, 1'b1);
    check_idle("rst_prio0");
    drive(4'd15, 4'd15, 1'b1, 1'b1);
    check_idle("rst_prio1");
    for (int k = 0; k < NDUT; k++) exp_q[k].delete();

    // First edge with rst low samples the input.
    drive(4'd15, 4'd15, 1'b1, 1'b0);
    for (int k = 0; k < NDUT; k++) exp_q[k].push_back({dir_hit[0][k], dir_out[0][k]});
    drive(4'd0, 4'd0, 1'b0, 1'b0);

    // Drain with a bounded wait, then require every queue empty.
    for (int i = 0; i < 10; i++) begin
      int pending;
      pending = 0;
      for (int k = 0; k < NDUT; k++) pending += exp_q[k].size();
      if (pending == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    for (int k = 0; k < NDUT; k++)
      check($sformatf("dut%0d pending results", k), exp_q[k].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
